// File: rtl/dac_sample_feeder_if.sv
// dac_sample_feeder_if: sample stream into the feeder and frame-rate stream out to the DAC serializer.
interface dac_sample_feeder_if #(parameter int DW = 16);
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_load;
   modport master (output s_data, s_valid, input s_ready, m_data, m_load);
   modport slave  (input s_data, s_valid, output s_ready, m_data, m_load);
endinterface

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: FIFO-buffers signed samples and releases one offset-binary sample per DAC frame.
// Define DAC_FEEDER_UNDERFLOW_MIDSCALE_EN to output midscale and re-prime on underflow instead of holding.
module dac_sample_feeder #(
   parameter int DW    = 16,
   parameter int DEPTH = 8,
   parameter int FRAME = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   dac_sample_feeder_if.slave     sif,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [15:0]            underflow_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(FRAME);
   localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]    HALF = (AW+1)'(DEPTH / 2);
   localparam logic [CW-1:0]  LAST = CW'(FRAME - 1);
   localparam logic [DW-1:0]  MID  = {1'b1, {DW-1{1'b0}}};
`ifdef DAC_FEEDER_UNDERFLOW_MIDSCALE_EN
   localparam bit UF_MID = 1'b1;
`else
   localparam bit UF_MID = 1'b0;
`endif
   typedef enum logic {PRIME, RUN} state_t;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] m_data_nxt;
   logic          tick, push, pop, empty_tick, prime_ok;

   assign sif.s_ready = !reset && fifo_level != FULL;
   assign push        = sif.s_valid && sif.s_ready;
   assign tick        = en && cnt == LAST;
   assign prime_ok    = fifo_level >= HALF;

   always_ff @(posedge clk)
      if (reset) state <= PRIME;
      else state <= state_nxt;

   always_comb
      state_nxt = (state == PRIME && tick && prime_ok) ? RUN :
                  (UF_MID && empty_tick) ? PRIME : state;

   // The priming tick already pops, so pop is qualified by prime_ok as well as RUN.
   always_comb begin
      pop        = tick && fifo_level != '0 && (state == RUN || prime_ok);
      empty_tick = tick && state == RUN && fifo_level == '0;
      m_data_nxt = pop ? mem[rd_ptr] ^ MID :
                   (tick && (state == PRIME || (UF_MID && empty_tick))) ? MID : sif.m_data;
   end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= sif.s_data;

   always_ff @(posedge clk)
      if (reset) begin
         cnt           <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         underflow_cnt <= '0;
         sif.m_load    <= 1'b0;
         sif.m_data    <= MID;
      end else begin
         if (en) cnt <= tick ? '0 : cnt + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= (push && !pop) ? fifo_level + 1'b1 :
                       (pop && !push) ? fifo_level - 1'b1 : fifo_level;
         if (empty_tick && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
         sif.m_load <= tick;
         sif.m_data <= m_data_nxt;
      end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: randomized stimulus against a queue-based frame model of the feeder.
module tb_dac_sample_feeder;
   localparam int DEPTH = 8;
   localparam int FRAME = 24;
   localparam logic [15:0] MID = 16'h8000;

   logic        clk = 1'b0;
   logic        reset, en;
   logic [3:0]  fifo_level;
   logic [15:0] underflow_cnt;
   int          total = 0, bad = 0;

   dac_sample_feeder_if #(.DW(16)) sif ();

   dac_sample_feeder #(.DW(16), .DEPTH(DEPTH), .FRAME(FRAME)) dut (
      .clk(clk), .reset(reset), .en(en), .sif(sif),
      .fifo_level(fifo_level), .underflow_cnt(underflow_cnt)
   );

   always #5 clk = ~clk;

   logic [15:0] q[$];
   int          cnt;
   bit          run, e_mload, acc;
   logic [15:0] e_mdata, e_uf, nxt;
   logic [15:0] dir_vals [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'h1234};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs now applied, then compare after the edge.
   task automatic step();
      bit tick;
      if (reset) begin
         q.delete();
         cnt = 0; run = 0; e_mdata = MID; e_mload = 0; e_uf = 0; acc = 0;
      end else begin
         acc  = sif.s_valid && q.size() < DEPTH;
         tick = en && cnt == FRAME - 1;
         if (en) cnt = (cnt + 1) % FRAME;
         e_mload = tick;
         if (tick) begin
            if (!run && q.size() >= DEPTH / 2) run = 1;
            if (run) begin
               if (q.size() > 0) e_mdata = q.pop_front() ^ MID;
               else begin
                  if (e_uf != 16'hFFFF) e_uf++;
`ifdef DAC_FEEDER_UNDERFLOW_MIDSCALE_EN
                  e_mdata = MID;
                  run = 0;
`endif
               end
            end else e_mdata = MID;
         end
         if (acc) q.push_back(sif.s_data);
      end
      @(posedge clk);
      #1;
      chk("m_load", 32'(sif.m_load), 32'(e_mload));
      chk("m_data", 32'(sif.m_data), 32'(e_mdata));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(e_uf));
      chk("s_ready", 32'(sif.s_ready), 32'(!reset && q.size() < DEPTH));
   endtask

   initial begin
      reset = 1; en = 1; sif.s_valid = 0; sif.s_data = '0;
      repeat (3) step();
      reset = 0;
      repeat (60) step();
      foreach (dir_vals[i]) begin
         sif.s_valid = 1; sif.s_data = dir_vals[i];
         step();
      end
      sif.s_valid = 0;
      repeat (FRAME * 6) step();
      // Push only on tick cycles with an empty FIFO
      repeat (150) begin
         sif.s_valid = (cnt == FRAME - 1 && q.size() == 0);
         sif.s_data  = 16'($urandom);
         step();
      end
      sif.s_valid = 0;
      nxt = 16'h0100;
      repeat (800) begin
         if (!sif.s_valid) sif.s_valid = $urandom_range(0, 1) == 1;
         en = $urandom_range(0, 9) != 0;
         sif.s_data = nxt;
         step();
         if (acc) begin
            nxt++;
            sif.s_valid = $urandom_range(0, 2) != 0;
         end
      end
      en = 1;
      repeat (200) begin
         sif.s_valid = 1; sif.s_data = nxt;
         step();
         if (acc) nxt++;
      end
      sif.s_valid = 0;
      for (int i = 0; i < FRAME && cnt != 10; i++) step();
      en = 0;
      repeat (10) step();
      en = 1;
      repeat (30) step();
      for (int i = 0; i < 40 && q.size() < DEPTH / 2; i++) begin
         sif.s_valid = 1; sif.s_data = 16'($urandom);
         step();
      end
      sif.s_valid = 0;
      for (int i = 0; i < FRAME && cnt != FRAME - 1; i++) step();
      reset = 1;
      step();
      reset = 0;
      repeat (FRAME * 3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
